// File: rtl/lcg_stim_pkg.sv
// Shared constants, FSM state type and LCG step function for the stimulus generator.
// The LCG matches the simulation bench so a given seed replays identically on hardware.
package lcg_stim_pkg;

   localparam logic [31:0] LCG_A        = 32'h41C64E6D;
   localparam logic [31:0] LCG_C        = 32'h3039;
   localparam logic [31:0] DEFAULT_SEED = 32'd3034658173;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      PRESENT,
      DONE
   } state_e;

   // One LCG step; the result is both the new state and the emitted word.
   function automatic logic [31:0] lcg_next(input logic [31:0] state);
      return state * LCG_A + LCG_C;
   endfunction

endpackage

// File: rtl/lcg_stim_gen.sv
// Packs a deterministic LCG stream into wide vectors and hands them out over valid/ready
// under a programmable vector budget, with busy/done status and a debug view of the LCG state.
module lcg_stim_gen #(
   parameter int          IN_W         = 135,
   parameter logic [31:0] DEFAULT_SEED = lcg_stim_pkg::DEFAULT_SEED
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     seed_i,
   input  logic            seed_load_i,
   input  logic            start_i,
   input  logic [31:0]     num_vec_i,
   output logic [IN_W-1:0] vec_o,
   output logic            vec_valid_o,
   input  logic            vec_ready_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [31:0]     vec_count_o,
   output logic [31:0]     rng_state_o
);

   import lcg_stim_pkg::*;

   localparam int NUM_WORDS = (IN_W + 31) / 32;
   localparam int SH_W      = 32 * (NUM_WORDS - 1);
   localparam int LAST_BITS = IN_W - SH_W;
   localparam int WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

   state_e            state_q, state_d;
   logic [31:0]       lcg_q, lcg_d;
   logic [SH_W-1:0]   shadow_q, shadow_d;
   logic [IN_W-1:0]   vec_q, vec_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [31:0]       budget_q, budget_d;
   logic [WCNT_W-1:0] word_q, word_d;
   logic [31:0]       step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         lcg_q    <= DEFAULT_SEED;
         shadow_q <= '0;
         vec_q    <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         budget_q <= '0;
         word_q   <= '0;
      end else begin
         state_q  <= state_d;
         lcg_q    <= lcg_d;
         shadow_q <= shadow_d;
         vec_q    <= vec_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         budget_q <= budget_d;
         word_q   <= word_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lcg_d    = lcg_q;
      shadow_d = shadow_q;
      vec_d    = vec_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      budget_d = budget_q;
      word_d   = word_q;
      step     = lcg_next(lcg_q);

      unique case (state_q)
         IDLE, DONE: begin
            // Reseeding is only possible from IDLE; DONE continues the existing stream.
            if (state_q == IDLE && seed_load_i) begin
               lcg_d = seed_i;
            end
            if (start_i) begin
               cnt_d = '0;
               if (num_vec_i == 32'd0) begin
                  state_d = DONE;
               end else begin
                  state_d  = FILL;
                  budget_d = num_vec_i;
                  word_d   = '0;
               end
            end
         end
         FILL: begin
            lcg_d = step;
            if (word_q == LAST_WORD) begin
               vec_d   = {step[LAST_BITS-1:0], shadow_q};
               valid_d = 1'b1;
               word_d  = '0;
               state_d = PRESENT;
            end else begin
               shadow_d[32*word_q +: 32] = step;
               word_d = word_q + 1'b1;
            end
         end
         PRESENT: begin
            if (vec_ready_i) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q + 32'd1;
               state_d = (cnt_d == budget_q) ? DONE : FILL;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == FILL) || (state_d == PRESENT);
      done_d = (state_d == DONE);
   end

   assign vec_o       = vec_q;
   assign vec_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign vec_count_o = cnt_q;
   assign rng_state_o = lcg_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Directed self-checking bench for lcg_stim_gen: reset values, packing, stalls,
// zero budget, mid-run reset and ignored seed loads, against an independent LCG model.
module tb_lcg_stim_gen;

   localparam int IN_W = 135;
   localparam logic [31:0] DEF_SEED = 32'd3034658173;

   logic            clk;
   logic            rstN;
   logic [31:0]     seedVal;
   logic            seedLoad;
   logic            startRun;
   logic [31:0]     numVec;
   logic [IN_W-1:0] vecOut;
   logic            vecValid;
   logic            vecReady;
   logic            busy;
   logic            done;
   logic [31:0]     vecCount;
   logic [31:0]     rngState;

   int checks   = 0;
   int failures = 0;

   logic [31:0]     modelState;
   logic [IN_W-1:0] expVec;
   logic [IN_W-1:0] firstVec;

   lcg_stim_gen #(.IN_W(IN_W)) dut (
      .clk         (clk),
      .rst_n       (rstN),
      .seed_i      (seedVal),
      .seed_load_i (seedLoad),
      .start_i     (startRun),
      .num_vec_i   (numVec),
      .vec_o       (vecOut),
      .vec_valid_o (vecValid),
      .vec_ready_i (vecReady),
      .busy_o      (busy),
      .done_o      (done),
      .vec_count_o (vecCount),
      .rng_state_o (rngState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference step computed in 64-bit arithmetic with decimal constants.
   function automatic logic [31:0] refStep(input logic [31:0] s);
      longint unsigned p;
      p = longint'(s) * 64'd1103515245 + 64'd12345;
      return p[31:0];
   endfunction

   task automatic makeVec(output logic [IN_W-1:0] v);
      v = '0;
      for (int k = 0; k < 5; k++) begin
         modelState = refStep(modelState);
         for (int b = 0; b < 32; b++) begin
            if (32 * k + b < IN_W) v[32*k+b] = modelState[b];
         end
      end
   endtask

   task automatic applyStimulus(input logic sl, input logic [31:0] sd, input logic st,
                                input logic [31:0] nv, input logic rd);
      seedLoad = sl;
      seedVal  = sd;
      startRun = st;
      numVec   = nv;
      vecReady = rd;
   endtask

   task automatic checkOutput(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitValid(input string tag);
      int n;
      n = 0;
      while (!vecValid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!vecValid) checkOutput(tag, 160'(vecValid), 160'd1);
   endtask

   task automatic doReset();
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      rstN = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      @(negedge clk);

      // Reset values.
      checkOutput("rst_vec",   160'(vecOut),   160'd0);
      checkOutput("rst_valid", 160'(vecValid), 160'd0);
      checkOutput("rst_busy",  160'(busy),     160'd0);
      checkOutput("rst_done",  160'(done),     160'd0);
      checkOutput("rst_count", 160'(vecCount), 160'd0);
      checkOutput("rst_rng",   160'(rngState), 160'(DEF_SEED));
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      // Default seed, single vector, ready high; exact latency.
      $display("[TB] default seed single vector");
      modelState = DEF_SEED;
      makeVec(expVec);
      applyStimulus(1'b0, 32'd0, 1'b1, 32'd1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t1_busy", 160'(busy), 160'd1);
      checkOutput("t1_valid_early", 160'(vecValid), 160'd0);
      repeat (4) @(negedge clk);
      checkOutput("t1_valid_e4", 160'(vecValid), 160'd0);
      @(negedge clk);
      checkOutput("t1_valid_e5", 160'(vecValid), 160'd1);
      checkOutput("t1_vec", 160'(vecOut), 160'(expVec));
      @(negedge clk);
      checkOutput("t1_valid_drop", 160'(vecValid), 160'd0);
      checkOutput("t1_done",  160'(done),     160'd1);
      checkOutput("t1_busy_done", 160'(busy), 160'd0);
      checkOutput("t1_count", 160'(vecCount), 160'd1);
      checkOutput("t1_rng",   160'(rngState), 160'(modelState));

      // Seed load ignored in DONE.
      applyStimulus(1'b1, 32'h1234, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("done_seed_ignored", 160'(rngState), 160'(modelState));

      // Seed 0 after reset.
      $display("[TB] seed zero");
      doReset();
      applyStimulus(1'b1, 32'd0, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      checkOutput("t2_seed_loaded", 160'(rngState), 160'd0);
      modelState = 32'd0;
      makeVec(expVec);
      applyStimulus(1'b0, 32'd0, 1'b1, 32'd1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      waitValid("t2_timeout");
      checkOutput("t2_word0", 160'(vecOut[31:0]),  160'h00003039);
      checkOutput("t2_word1", 160'(vecOut[63:32]), 160'hD3DC167E);
      checkOutput("t2_vec",   160'(vecOut),        160'(expVec));
      @(negedge clk);
      checkOutput("t2_done", 160'(done), 160'd1);

      // Three vectors from DONE, stream continues; stall vector 2 with seed pulse in PRESENT.
      $display("[TB] three vectors with stall");
      applyStimulus(1'b0, 32'd0, 1'b1, 32'd3, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      checkOutput("t3_count_clear", 160'(vecCount), 160'd0);
      checkOutput("t3_done_clear",  160'(done),     160'd0);
      makeVec(expVec);
      waitValid("t3_v1_timeout");
      checkOutput("t3_v1", 160'(vecOut), 160'(expVec));
      vecReady = 1'b1;
      @(negedge clk);
      vecReady = 1'b0;
      checkOutput("t3_count1", 160'(vecCount), 160'd1);
      checkOutput("t3_v1_drop", 160'(vecValid), 160'd0);
      makeVec(expVec);
      waitValid("t3_v2_timeout");
      for (int i = 0; i < 10; i++) begin
         checkOutput("t3_stall_vec",   160'(vecOut),   160'(expVec));
         checkOutput("t3_stall_valid", 160'(vecValid), 160'd1);
         applyStimulus((i == 3), 32'hDEADBEEF, (i == 5), 32'd7, 1'b0);
         @(negedge clk);
         applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      end
      checkOutput("t3_stall_count", 160'(vecCount), 160'd1);
      vecReady = 1'b1;
      @(negedge clk);
      checkOutput("t3_count2", 160'(vecCount), 160'd2);
      // Seed load and start during FILL of vector 3 must be ignored.
      applyStimulus(1'b1, 32'hCAFEF00D, 1'b1, 32'd9, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      makeVec(expVec);
      waitValid("t3_v3_timeout");
      checkOutput("t3_v3", 160'(vecOut), 160'(expVec));
      checkOutput("t3_done_not_yet", 160'(done), 160'd0);
      vecReady = 1'b1;
      @(negedge clk);
      checkOutput("t3_count3", 160'(vecCount), 160'd3);
      checkOutput("t3_done",   160'(done),     160'd1);
      checkOutput("t3_rng",    160'(rngState), 160'(modelState));

      // Zero budget from IDLE.
      $display("[TB] zero budget");
      doReset();
      applyStimulus(1'b0, 32'd0, 1'b1, 32'd0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      checkOutput("t4_done", 160'(done), 160'd1);
      checkOutput("t4_busy", 160'(busy), 160'd0);
      for (int i = 0; i < 6; i++) begin
         checkOutput("t4_no_valid", 160'(vecValid), 160'd0);
         @(negedge clk);
      end
      checkOutput("t4_rng", 160'(rngState), 160'(DEF_SEED));

      // Reset during FILL of vector 2, then replay vector 1.
      $display("[TB] reset mid-run");
      doReset();
      modelState = DEF_SEED;
      makeVec(firstVec);
      applyStimulus(1'b0, 32'd0, 1'b1, 32'd2, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      waitValid("t5_v1_timeout");
      checkOutput("t5_v1", 160'(vecOut), 160'(firstVec));
      repeat (3) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      checkOutput("t5_rst_vec",   160'(vecOut),   160'd0);
      checkOutput("t5_rst_valid", 160'(vecValid), 160'd0);
      checkOutput("t5_rst_busy",  160'(busy),     160'd0);
      checkOutput("t5_rst_done",  160'(done),     160'd0);
      checkOutput("t5_rst_count", 160'(vecCount), 160'd0);
      checkOutput("t5_rst_rng",   160'(rngState), 160'(DEF_SEED));
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b1, 32'd1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      waitValid("t5_replay_timeout");
      checkOutput("t5_replay", 160'(vecOut), 160'(firstVec));
      @(negedge clk);
      checkOutput("t5_replay_done", 160'(done), 160'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcg_stim_gen.md
# lcg_stim_gen

Synthesizable stimulus source that sits directly upstream of the fuzzing DUT wrapper `top`. It produces the same deterministic 32-bit LCG stream the simulation bench uses and packs it into wide `in_flat`-style vectors, so FPGA/emulation runs replay the exact stimulus of a given seed. Vectors are delivered over a valid/ready handshake under a programmable vector budget, with busy/done status.

## Interface
Parameters:
- `IN_W`, 135: output vector width in bits.
- `NUM_WORDS`, derived as ceil(IN_W/32) = 5: LCG steps per vector.
- `DEFAULT_SEED`, 32'd3034658173: LCG state loaded on reset.

Ports (clock and reset first):
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `seed_i`  in  32: seed value.
- `seed_load_i`  in  1: load `seed_i` into LCG state; honoured only in IDLE.
- `start_i`  in  1: begin a run; honoured in IDLE and DONE.
- `num_vec_i`  in  32: vectors to emit; sampled with `start_i`.
- `vec_o`  out  IN_W: current vector.
- `vec_valid_o`  out  1: `vec_o` holds an unconsumed vector.
- `vec_ready_i`  in  1: consumer accepts the vector.
- `busy_o`  out  1: FSM in FILL or PRESENT.
- `done_o`  out  1: FSM in DONE.
- `vec_count_o`  out  32: vectors accepted in the current run.
- `rng_state_o`  out  32: current LCG state, for debug and replay.

## Operation
- LCG step: next = (state * 32'h41C64E6D + 32'h3039) mod 2^32. Each step output is the new state.
- Packing: step k (k = 0..NUM_WORDS-1) fills bits [32k+31:32k]. The last word keeps only its low IN_W-32*(NUM_WORDS-1) bits (7 at the default width).
- The vector is assembled in a shadow register. `vec_o` is copied from the shadow on the final step only, so `vec_o` never shows a partial vector.
- FSM states:
  - IDLE: `seed_load_i` loads the state. `start_i` with `num_vec_i` = 0 goes to DONE; `start_i` with a non-zero count goes to FILL and clears the count. If `seed_load_i` and `start_i` are both high, the seed is loaded first and FILL begins from the new seed.
  - FILL: one LCG step per clock. After step NUM_WORDS-1, copy shadow to `vec_o`, set valid, go to PRESENT.
  - PRESENT: hold `vec_o` and valid stable while `vec_ready_i` = 0. On the handshake, `vec_count_o`++. If the count then equals the budget, go to DONE; otherwise go to FILL.
  - DONE: `start_i` starts a new run (same rules as IDLE). The LCG stream continues from the current state and is not reseeded. `seed_load_i` is ignored in DONE. To reseed, apply reset, which returns the FSM to IDLE.
- `seed_load_i` in FILL or PRESENT is ignored. `start_i` in FILL or PRESENT is ignored.
- Reset values: state = IDLE, LCG state = DEFAULT_SEED, `vec_o` = 0, `vec_valid_o` = 0, `busy_o` = 0, `done_o` = 0, `vec_count_o` = 0.
- Reset asserted mid-run aborts the run immediately and clears all outputs asynchronously. A partial vector is discarded.
- `vec_count_o` is a 32-bit counter. The budget comparison prevents wrap; a budget of 2^32-1 is legal.

## Timing
- Start accepted at edge E0: the words are written at edges E1..E_NUM_WORDS, and `vec_valid_o` is high after edge E_NUM_WORDS (5 cycles at default).
- Handshake at edge H: valid drops after H. The next vector is valid after edge H+NUM_WORDS.
- Maximum throughput is one vector per NUM_WORDS+1 cycles.
- `done_o` rises on the edge that accepts the final vector.
- All outputs are registered. There is no combinational path from `vec_ready_i` to `vec_valid_o`.

## Structure
- Package `lcg_stim_pkg` holds:
  - the constants LCG_A = 32'h41C64E6D, LCG_C = 32'h3039 and DEFAULT_SEED;
  - the state enum {IDLE, FILL, PRESENT, DONE};
  - the function `lcg_next(logic [31:0])`.
- No sub-module. The step is the package function, and the FSM, word counter and vector counter stay in one module.

## Test plan
- Reset with no seed load, start with `num_vec_i` = 1, ready held high: word0 equals the first LCG step from 3034658173, checked against the bench reference model; `done_o` = 1 and count = 1 afterwards.
- Seed 0 loaded, start with `num_vec_i` = 1: `vec_o[31:0]` = 32'h00003039, `vec_o[63:32]` = 32'hD3DC167E, and bits above 134 are not present.
- `num_vec_i` = 3 with `vec_ready_i` low for 10 cycles on vector 2: `vec_o` is stable and valid stays high throughout; count steps 1, 2, 3; DONE follows the third handshake.
- `num_vec_i` = 0: `done_o` is high one cycle after start, `vec_valid_o` never rises, and `rng_state_o` is unchanged.
- `rst_n` asserted during FILL of vector 2: all outputs go to their reset values immediately and `rng_state_o` = DEFAULT_SEED; a new run reproduces vector 1 exactly.
- `seed_load_i` pulsed during FILL and during PRESENT: the pulse is ignored and the vector stream matches an unperturbed run.
